// File: rtl/rv32_dmem_pkg.sv
// rv32_dmem_pkg: shared FSM state type and width constants for the RV32 data-memory responder.
package rv32_dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int WSTRB_WIDTH = 4;
  localparam int WAIT_CNT_WIDTH = 4;
endpackage

// File: rtl/rv32_dmem_bank.sv
// rv32_dmem_bank: synchronous single-port 32-bit RAM with byte-lane write mask and registered read data.
module rv32_dmem_bank
  import rv32_dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [WSTRB_WIDTH-1:0] be,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < WSTRB_WIDTH; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (en && !we) rdata <= mem[addr];
  end
endmodule

// File: rtl/rv32_dmem_responder.sv
// rv32_dmem_responder: one-outstanding data-memory responder with wait states and valid/ready channels.
// Define RV32_DMEM_FAULT_EN to fault misaligned or out-of-range addresses instead of aliasing them.
module rv32_dmem_responder
  import rv32_dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [WSTRB_WIDTH-1:0] req_wstrb,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_rdata,
  output logic                   resp_fault
);
  state_t state, state_nx;
  logic [WAIT_CNT_WIDTH-1:0] cnt;
  logic w_q, f_q, accept, access, fault, acc_write;
  logic [31:0] a_q, d_q, acc_addr, acc_wdata, bank_rdata;
  logic [WSTRB_WIDTH-1:0] s_q, acc_wstrb;
  assign accept = state == IDLE && req_valid;
  assign access = (accept && WAIT_STATES == 0) || (state == WAIT && cnt == '0);
  // With no wait states the access happens at the accept edge, so it must use the live request.
  assign acc_addr  = state == IDLE ? req_addr  : a_q;
  assign acc_wdata = state == IDLE ? req_wdata : d_q;
  assign acc_wstrb = state == IDLE ? req_wstrb : s_q;
  assign acc_write = state == IDLE ? req_write : w_q;
`ifdef RV32_DMEM_FAULT_EN
  assign fault = (|acc_addr[1:0]) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^acc_addr;
  assign fault = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (req_valid ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE)
             : state == WAIT ? (cnt == '0 ? RESP : WAIT)
             : (resp_ready ? IDLE : RESP);
  always_comb begin
    req_ready  = state == IDLE;
    resp_valid = state == RESP;
    resp_rdata = (state == RESP && !w_q && !f_q) ? bank_rdata : '0;
    resp_fault = state == RESP && f_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      w_q <= 1'b0;
      f_q <= 1'b0;
      a_q <= '0;
      d_q <= '0;
      s_q <= '0;
    end else begin
      if (accept) begin
        cnt <= WAIT_CNT_WIDTH'(WAIT_STATES - 1);
        w_q <= req_write;
        a_q <= req_addr;
        d_q <= req_wdata;
        s_q <= req_wstrb;
      end else if (state == WAIT) cnt <= cnt - 1'b1;
      if (access) f_q <= fault;
    end
  end
  rv32_dmem_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
    .clk  (clk),
    .en   (access && !fault),
    .we   (acc_write),
    .be   (acc_wstrb),
    .addr (acc_addr[ADDR_WIDTH+1:2]),
    .wdata(acc_wdata),
    .rdata(bank_rdata)
  );
endmodule

// File: doc/rv32_dmem_responder.md
Name: rv32_dmem_responder

Overview:
- Data-memory responder (slave) for the RV32 pipeline's load/store path.
- The memory stage issues one request at a time over a valid/ready request channel.
- This block performs the word access against a local byte-lane-writable RAM, inserts configurable wait states, and returns the result over a valid/ready response channel.
- At most one transaction is outstanding.

Parameters:
- ADDR_WIDTH, 8, word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits.
- WAIT_STATES, 0, extra cycles between accept and access (legal range 0..15).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, lane-aligned
- req_wstrb  in  4  store byte-lane enables (bit i = byte i); ignored on loads
- resp_valid  out  1  response present
- resp_ready  in  1  initiator accepts response
- resp_rdata  out  32  load data; 0 for stores
- resp_fault  out  1  access error (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - state = IDLE, wait counter = 0.
  - resp_valid = 0, resp_rdata = 0, resp_fault = 0.
  - req_ready = 1 after reset release.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1; accept on req_valid && req_ready at an edge.
  - On accept, capture write, addr, wdata, wstrb.
  - WAIT_STATES == 0: perform the access at the accept edge and go to RESP.
  - WAIT_STATES > 0: load counter = WAIT_STATES-1 and go to WAIT.
- WAIT:
  - req_ready = 0; counter decrements each cycle.
  - At counter == 0, perform the access at that edge and go to RESP.
- Access:
  - Word index = addr[ADDR_WIDTH+1:2]. Upper address bits alias (wrap-around) unless the fault feature is on.
  - Load: resp_rdata <= full word.
  - Store: write each byte i where wstrb[i] = 1; resp_rdata <= 0.
  - A store with wstrb = 0000 completes normally and writes nothing.
- RESP:
  - resp_valid = 1; resp_rdata and resp_fault held stable until resp_ready = 1 at an edge, then go to IDLE with resp_valid <= 0.
  - req_ready = 0 throughout RESP, including the handshake cycle.
- Timing:
  - Latency: accept at edge N, resp_valid high after edge N+WAIT_STATES.
  - Throughput: one transaction per 2+WAIT_STATES cycles with resp_ready held at 1.
- Boundary and ordering rules:
  - Request fields need not stay stable after accept; the block uses only the captured copy.
  - A load following a store to the same word returns the new data, since there is no overlap.
  - Reset asserted in WAIT drops the pending store (RAM unchanged).
  - Reset asserted in RESP leaves the committed store in RAM and drops the response.

Optional Feature:
- Macro: RV32_DMEM_FAULT_EN.
- Defined: a request faults if addr[1:0] != 0, or if any addr bit above ADDR_WIDTH+1 is nonzero. A faulting request:
  - suppresses the RAM access (no write);
  - returns resp_rdata = 0 and resp_fault = 1;
  - keeps the same timing as a normal request.
- Undefined: resp_fault is tied to 0; addr[1:0] is ignored; upper bits alias.

Decomposition:
- Package rv32_dmem_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - the WSTRB_WIDTH = 4 constant;
  - the WAIT_CNT_WIDTH = 4 constant.
- Sub-module rv32_dmem_bank is a synchronous single-port RAM, parameterised by ADDR_WIDTH, with:
  - en, we, a 4-bit byte-write mask, addr, wdata;
  - rdata registered on en && !we.

Test Plan:
- WAIT_STATES=0: store 0xDEADBEEF @0x10 wstrb=1111, then load @0x10 -> resp_rdata=0xDEADBEEF, resp_valid 1 cycle after accept.
- Byte lane: store 0x0000AA00 @0x10 wstrb=0010 over 0xDEADBEEF -> load returns 0xDEADAAEF; wstrb=0000 store -> unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles on a load -> resp_valid=1, rdata stable, req_ready=0 all 5 cycles; IDLE one cycle after handshake.
- WAIT_STATES=3: accept at edge N -> resp_valid rises after edge N+3; reset pulsed mid-WAIT on store 0x12345678 @0x20 -> later load @0x20 returns the prior value.
- Aliasing (macro off, ADDR_WIDTH=8): store 0xCAFEF00D @0x400 -> load @0x000 returns 0xCAFEF00D, resp_fault=0.
- Fault (macro on): store @0x13 or @0x400 -> resp_fault=1, rdata=0, RAM unchanged; aligned in-range access -> resp_fault=0.
